// File: rtl/pingpong_line_reader.sv
// Reads whole video lines alternately from a ping and a pong line FIFO and
// streams them out as a valid/ready pixel stream with end-of-line marking.
module pingpong_line_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_LEN   = 1920,
  parameter int LVL_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof_clr,
  input  logic [DATA_WIDTH-1:0] ping_rd_data,
  input  logic                  ping_rd_empty,
  input  logic [LVL_WIDTH-1:0]  ping_rd_water_level,
  output logic                  ping_rd_en,
  input  logic [DATA_WIDTH-1:0] pong_rd_data,
  input  logic                  pong_rd_empty,
  input  logic [LVL_WIDTH-1:0]  pong_rd_water_level,
  output logic                  pong_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  line_done,
  output logic                  underflow
);
  localparam int CNT_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(LINE_LEN - 1);
  localparam logic [LVL_WIDTH-1:0] LVL_THR = LVL_WIDTH'(LINE_LEN);

  typedef enum logic [1:0] {WAIT_PING, RD_PING, WAIT_PONG, RD_PONG} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      rd_cnt, beat_cnt;
  logic [1:0]            occ;
  logic                  inflight, inflight_pong;
  logic [DATA_WIDTH-1:0] skid0, skid1, rd_word;
  logic [2:0]            fill;
  logic                  pop, push, room, rd_issue;

  assign pop      = m_valid & m_ready;
  assign push     = inflight;
  // A slot freed by a same-cycle pop counts as free, otherwise 1 beat/clk is unreachable.
  assign fill     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign room     = (fill < 3'd2);
  assign rd_issue = ping_rd_en | pong_rd_en;
  assign rd_word  = inflight_pong ? pong_rd_data : ping_rd_data;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = skid0;
  assign m_last    = m_valid & (beat_cnt == LAST);
  assign line_done = pop & m_last;

  always_comb begin
    state_nxt  = state;
    ping_rd_en = 1'b0;
    pong_rd_en = 1'b0;
    if (sof_clr) begin
      state_nxt = WAIT_PING;
    end else begin
      case (state)
        WAIT_PING: if (ping_rd_water_level >= LVL_THR) state_nxt = RD_PING;
        RD_PING: begin
          ping_rd_en = room;
          if (room && rd_cnt == LAST) state_nxt = WAIT_PONG;
        end
        WAIT_PONG: if (pong_rd_water_level >= LVL_THR) state_nxt = RD_PONG;
        RD_PONG: begin
          pong_rd_en = room;
          if (room && rd_cnt == LAST) state_nxt = WAIT_PING;
        end
        default: state_nxt = WAIT_PING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_PING;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_pong <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= rd_issue;
      inflight_pong <= pong_rd_en;
      if (sof_clr)       rd_cnt <= '0;
      else if (rd_issue) rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
    end
  end

  // Two-entry skid buffer, skid0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else if (sof_clr) begin
      occ   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= rd_word;
          else             skid1 <= rd_word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= rd_word;
          end else begin
            skid0 <= skid1;
            skid1 <= rd_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      if (sof_clr)  beat_cnt <= '0;
      else if (pop) beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
      if ((ping_rd_en & ping_rd_empty) | (pong_rd_en & pong_rd_empty))
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_line_reader.sv
// Directed bench: behavioural ping/pong FIFOs with one-cycle read latency and
// a negedge stream monitor that scores data order, framing and stalls.
module tb_pingpong_line_reader;
  localparam int DATA_WIDTH = 16;
  localparam int LINE_LEN   = 1920;
  localparam int LVL_WIDTH  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof_clr = 1'b0;
  logic [DATA_WIDTH-1:0] ping_rd_data = '0, pong_rd_data = '0;
  logic ping_rd_empty, pong_rd_empty, ping_rd_en, pong_rd_en;
  logic [LVL_WIDTH-1:0] ping_rd_water_level, pong_rd_water_level;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_valid, m_ready, m_last, line_done, underflow;
  logic rnd_mode = 1'b0, rnd_rdy = 1'b0, dir_rdy = 1'b1;

  int ping_wr = 0, pong_wr = 0, ping_rd = 0, pong_rd = 0, ping_lie = 0, pong_lie = 0;
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;

  pingpong_line_reader #(.DATA_WIDTH(DATA_WIDTH), .LINE_LEN(LINE_LEN), .LVL_WIDTH(LVL_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .sof_clr(sof_clr),
    .ping_rd_data(ping_rd_data), .ping_rd_empty(ping_rd_empty),
    .ping_rd_water_level(ping_rd_water_level), .ping_rd_en(ping_rd_en),
    .pong_rd_data(pong_rd_data), .pong_rd_empty(pong_rd_empty),
    .pong_rd_water_level(pong_rd_water_level), .pong_rd_en(pong_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .line_done(line_done), .underflow(underflow));

  // FIFO models: ping words are their index, pong words carry bit 15.
  assign ping_rd_empty = (ping_wr == ping_rd);
  assign pong_rd_empty = (pong_wr == pong_rd);
  assign ping_rd_water_level = LVL_WIDTH'(ping_wr - ping_rd + ping_lie);
  assign pong_rd_water_level = LVL_WIDTH'(pong_wr - pong_rd + pong_lie);
  assign m_ready = rnd_mode ? rnd_rdy : dir_rdy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ping_rd_en) begin
      ping_rd_data <= DATA_WIDTH'(ping_rd);
      if (ping_rd != ping_wr) ping_rd <= ping_rd + 1;
    end
    if (pong_rd_en) begin
      pong_rd_data <= 16'h8000 | DATA_WIDTH'(pong_rd);
      if (pong_rd != pong_wr) pong_rd <= pong_rd + 1;
    end
  end

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 9) < 3);
  end

  // Stream monitor
  logic mon_en = 1'b0, mon_clr = 1'b0, mon_src_init = 1'b0;
  logic src = 1'b0, prev_stall = 1'b0, xfer, exp_last;
  logic [DATA_WIDTH-1:0] prev_data = '0, exp_d;
  int bcnt = 0, mon_beats = 0, mon_lines = 0, mon_ld = 0, reads_m = 0, xfers_m = 0;
  int idle = 0, max_idle = 0, first_rd = -1, first_x = -1, last_x = -1;
  int ping_idx = 0, pong_idx = 0, ping_rds = 0, pong_rds = 0;
  int both_err = 0, stall_err = 0, data_err = 0, occ_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ping_rd_en && pong_rd_en) both_err++;
      if (ping_rd_en) ping_rds++;
      if (pong_rd_en) pong_rds++;
    end
    if (mon_clr) begin
      src = mon_src_init; bcnt = 0; mon_beats = 0; mon_lines = 0; mon_ld = 0;
      reads_m = 0; xfers_m = 0; idle = 0; max_idle = 0; prev_stall = 1'b0;
      first_rd = -1; first_x = -1; last_x = -1;
    end else if (mon_en && rst_n) begin
      xfer = m_valid && m_ready;
      if (ping_rd_en || pong_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        reads_m++;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      exp_last = (bcnt == LINE_LEN - 1);
      if (m_valid && m_last !== exp_last) data_err++;
      if (line_done !== (xfer && exp_last)) data_err++;
      if (line_done) mon_ld++;
      if (xfer) begin
        exp_d = src ? (16'h8000 | DATA_WIDTH'(pong_idx)) : DATA_WIDTH'(ping_idx);
        if (m_data !== exp_d) data_err++;
        if (src) pong_idx++; else ping_idx++;
        if (first_x < 0) first_x = cyc;
        else if (idle > max_idle) max_idle = idle;
        idle = 0; last_x = cyc; xfers_m++; mon_beats++;
        if (exp_last) begin bcnt = 0; src = !src; mon_lines++; end
        else bcnt++;
      end else if (first_x >= 0) begin
        idle++;
      end
      if (reads_m - xfers_m > 2) occ_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_lines(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && mon_lines < n; i++) @(negedge clk);
    chk(tag, 32'(mon_lines >= n), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ping_en"}, 32'(ping_rd_en), 32'd0);
    chk({tag, "_pong_en"}, 32'(pong_rd_en), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_ldone"}, 32'(line_done), 32'd0);
    chk({tag, "_uflow"}, 32'(underflow), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
  endtask

  task automatic clr_mon(input logic s);
    mon_src_init = s;
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    clr_mon(1'b0);

    // Threshold: 1919 words must not start a read, 1920 must
    @(posedge clk); #1 ping_wr = LINE_LEN - 1;
    repeat (6) @(posedge clk);
    chk("thr_1919_no_rd", 32'(ping_rds), 32'd0);
    #1 ping_wr = LINE_LEN;
    @(negedge clk);
    chk("thr_same_cycle", 32'(ping_rd_en), 32'd0);
    @(negedge clk);
    chk("thr_rd_next", 32'(ping_rd_en), 32'd1);

    // Single ping line at full rate
    wait_lines(1, 3000, "line1_timeout");
    chk("line1_beats", 32'(mon_beats), 32'(LINE_LEN));
    chk("line1_latency", 32'(first_x - first_rd), 32'd2);
    chk("line1_span", 32'(last_x - first_x), 32'(LINE_LEN - 1));
    chk("line1_ldone", 32'(mon_ld), 32'd1);
    chk("line1_data", 32'(data_err), 32'd0);
    chk("line1_reads", 32'(ping_rds), 32'(LINE_LEN));

    // WAIT_PONG: ping data alone must not be read
    @(posedge clk); #1 ping_wr = LINE_LEN * 3;
    repeat (10) @(posedge clk);
    chk("wait_pong_hold", 32'(ping_rds + pong_rds), 32'(LINE_LEN));

    // Restart on ping, then alternate two lines from each FIFO
    #1 sof_clr = 1'b1; pong_wr = LINE_LEN * 2;
    clr_mon(1'b0);
    @(posedge clk); #1 sof_clr = 1'b0;
    wait_lines(4, 9000, "alt_timeout");
    chk("alt_beats", 32'(mon_beats), 32'(LINE_LEN * 4));
    chk("alt_gap", 32'(max_idle <= 2), 32'd1);
    chk("alt_data", 32'(data_err), 32'd0);
    chk("alt_ldone", 32'(mon_ld), 32'd4);

    // Random 30% ready
    @(posedge clk); #1 rnd_mode = 1'b1; ping_wr = LINE_LEN * 4;
    clr_mon(1'b0);
    wait_lines(1, 20000, "rnd_timeout");
    repeat (5) @(posedge clk);
    #1 rnd_mode = 1'b0;
    chk("rnd_beats", 32'(mon_beats), 32'(LINE_LEN));
    chk("rnd_data", 32'(data_err), 32'd0);
    chk("rnd_stall", 32'(stall_err), 32'd0);
    chk("rnd_occ", 32'(occ_err), 32'd0);

    // sof_clr part-way through a pong line
    @(posedge clk); #1 pong_wr = LINE_LEN * 3;
    clr_mon(1'b1);
    for (int i = 0; i < 3000 && mon_beats < 700; i++) @(negedge clk);
    chk("sof_reach_700", 32'(mon_beats >= 700), 32'd1);
    @(posedge clk); #1 sof_clr = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1 sof_clr = 1'b0;
    @(negedge clk);
    chk("sof_valid", 32'(m_valid), 32'd0);
    chk("sof_pong_en", 32'(pong_rd_en), 32'd0);
    chk("sof_ping_en", 32'(ping_rd_en), 32'd0);
    chk("sof_uflow", 32'(underflow), 32'd0);
    // Beat counter restarted: next ping line must frame at exactly LINE_LEN
    @(posedge clk); #1 ping_wr = LINE_LEN * 5; mon_en = 1'b1;
    clr_mon(1'b0);
    wait_lines(1, 3000, "post_sof_timeout");
    chk("post_sof_beats", 32'(mon_beats), 32'(LINE_LEN));
    chk("post_sof_data", 32'(data_err), 32'd0);
    chk("post_sof_latency", 32'(first_x - first_rd), 32'd2);

    // Underflow: level overstates content, then async reset mid-line
    mon_en = 1'b0;
    chk("uflow_clear", 32'(underflow), 32'd0);
    @(posedge clk); #1 pong_lie = LINE_LEN;
    repeat (1500) @(posedge clk);
    #1;
    chk("uflow_set", 32'(underflow), 32'd1);
    chk("midline_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    chk("both_rd_en", 32'(both_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
